fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
Program-counter and fetch controller directly upstream of the 16-entry instruction ROM. It drives the ROM's 4-bit address and latches the returned 8-bit instruction into an instruction register. It presents that instruction to the decoder/execute stage through a valid/ready handshake. It also handles sequential PC increment, taken branches, stalls via backpressure, and a sticky halt.

Parameters:
ADDR_W, 4, PC/ROM address width (16 instructions)
INSTR_W, 8, instruction width; opcode = instr[INSTR_W-1:INSTR_W-4]
HALT_OP, 4'b1110, opcode that halts fetching once accepted downstream
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
instr  in  8  instruction returned by ROM for address pc (combinational, same cycle)
pc  out  4  program counter; drives ROM addr
ir  out  8  instruction register presented downstream
ir_valid  out  1  ir holds an instruction not yet accepted
ir_ready  in  1  downstream accepts ir this cycle when ir_valid=1
branch_taken  in  1  sampled only on an accept cycle; redirect PC
branch_target  in  4  target PC when branch_taken
halted  out  1  sticky; HALT instruction accepted
retired  out  8  count of accepted instructions, saturating at 255

Behaviour:
- Reset (rst_n=0, async): state=FETCH, pc=RESET_PC, ir=8'hF0 (NOP), ir_valid=0, halted=0, retired=0.
- FSM states: FETCH, ISSUE, HALT.
- FETCH: ROM reads pc combinationally. On the clock edge: ir<=instr, ir_valid<=1, state->ISSUE. Fetch latency is 1 cycle from pc change to ir_valid=1.
- ISSUE: ir and ir_valid hold stable while ir_ready=0; that is the stall, and it may last indefinitely.
- ISSUE, on accept (ir_valid & ir_ready):
  - ir_valid<=0; retired increments unless already 255.
  - If ir[7:4]==HALT_OP: state->HALT, halted<=1, pc unchanged. branch_taken is ignored.
  - Else if branch_taken: pc<=branch_target, state->FETCH.
  - Else: pc<=pc+1 modulo 16 (15 wraps to 0), state->FETCH.
- Back-to-back throughput: one instruction per 2 cycles (FETCH, ISSUE).
- HALT: terminal. pc, ir and retired frozen; ir_valid=0; halted=1. ir_ready and branch inputs are ignored. Exit only by reset.
- branch_taken/branch_target are don't-care outside accept cycles.
- ir_ready asserted while ir_valid=0 has no effect.
- Reset asserted mid-ISSUE or in HALT returns all outputs to reset values immediately, without waiting for a clock edge. The first FETCH occurs on the first rising edge after rst_n rises.
- Outputs are registered except pc, which is a register driving the ROM address directly. No combinational path from ir_ready to ir_valid.

Test Plan:
- Reset, then ROM {0:8'h12, 1:8'h34}, ir_ready=1 constant -> ir=8'h12 valid at cycle 1, ir=8'h34 at cycle 3; pc sequence 0,0,1,1,2; retired=2 after two accepts.
- ir_ready=0 for 5 cycles while ir=8'h12 -> ir_valid held at 1, ir and pc stable; on ir_ready=1 exactly one retire and pc=1.
- Accept at pc=3 with branch_taken=1, branch_target=4'hA -> next pc=10; ROM[10] appears in ir one cycle later. branch_taken pulsed in a non-accept cycle -> no effect.
- Run sequentially through pc=15, no branch -> pc wraps to 0 and ROM[0] is refetched.
- ROM[2]=8'hE0 (HALT) -> after accept: halted=1, pc=2, ir_valid=0 forever, retired=3 and frozen despite ir_ready/branch activity; then assert rst_n=0 -> halted=0, pc=0 asynchronously.
- Force 300 accepts (loop via branch to 0) -> retired saturates at 255; mid-stall rst_n pulse -> ir=8'hF0, ir_valid=0 without a clock edge.

Source files
------------

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC/fetch controller feeding an instruction register through a valid/ready handshake
module fetch_sequencer #(
    parameter int                ADDR_W   = 4,
    parameter int                INSTR_W  = 8,
    parameter logic [3:0]        HALT_OP  = 4'b1110,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  pc,
    output logic [INSTR_W-1:0] ir,
    output logic               ir_valid,
    input  logic               ir_ready,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic               halted,
    output logic [7:0]         retired
);

    localparam logic [INSTR_W-1:0] NOP = {4'hF, {(INSTR_W-4){1'b0}}};

    typedef enum logic [1:0] {
        S_FETCH,
        S_ISSUE,
        S_HALT
    } state_t;

    state_t state;

    // ir_valid is high exactly while in S_ISSUE, so an accept is simply ir_ready there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_FETCH;
            pc       <= RESET_PC;
            ir       <= NOP;
            ir_valid <= 1'b0;
            halted   <= 1'b0;
            retired  <= 8'd0;
        end else begin
            case (state)
                S_FETCH: begin
                    ir       <= instr;
                    ir_valid <= 1'b1;
                    state    <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (ir_ready) begin
                        ir_valid <= 1'b0;
                        if (retired != 8'hFF) begin
                            retired <= retired + 8'd1;
                        end
                        if (ir[INSTR_W-1 -: 4] == HALT_OP) begin
                            halted <= 1'b1;
                            state  <= S_HALT;
                        end else if (branch_taken) begin
                            pc    <= branch_target;
                            state <= S_FETCH;
                        end else begin
                            pc    <= pc + {{(ADDR_W-1){1'b0}}, 1'b1};
                            state <= S_FETCH;
                        end
                    end
                end
                S_HALT: begin
                    ir_valid <= 1'b0;
                    halted   <= 1'b1;
                end
                default: begin
                    state <= S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - randomized and directed checks of fetch_sequencer against a behavioural model
module tb_fetch_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] instr;
    logic [3:0] pc;
    logic [7:0] ir;
    logic       ir_valid;
    logic       ir_ready = 1'b0;
    logic       branch_taken = 1'b0;
    logic [3:0] branch_target = 4'h0;
    logic       halted;
    logic [7:0] retired;

    logic [7:0] rom [16];
    assign instr = rom[pc];

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr        (instr),
        .pc           (pc),
        .ir           (ir),
        .ir_valid     (ir_valid),
        .ir_ready     (ir_ready),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .halted       (halted),
        .retired      (retired)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [3:0] m_pc;
    logic [7:0] m_ir;
    logic       m_valid;
    logic       m_halt;
    int         m_ret;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"},       {28'd0, pc},       {28'd0, m_pc});
        check({tag, ".ir"},       {24'd0, ir},       {24'd0, m_ir});
        check({tag, ".ir_valid"}, {31'd0, ir_valid}, {31'd0, m_valid});
        check({tag, ".halted"},   {31'd0, halted},   {31'd0, m_halt});
        check({tag, ".retired"},  {24'd0, retired},  m_ret);
    endtask

    task automatic model_reset();
        m_pc    = 4'd0;
        m_ir    = 8'hF0;
        m_valid = 1'b0;
        m_halt  = 1'b0;
        m_ret   = 0;
    endtask

    // Advance the model by one clock using the inputs currently applied, then clock the DUT and compare.
    task automatic step(input string tag);
        if (!m_halt) begin
            if (!m_valid) begin
                m_ir    = rom[m_pc];
                m_valid = 1'b1;
            end else if (ir_ready) begin
                m_valid = 1'b0;
                if (m_ret < 255) m_ret = m_ret + 1;
                if (m_ir[7:4] == 4'hE) m_halt = 1'b1;
                else if (branch_taken) m_pc = branch_target;
                else m_pc = m_pc + 4'd1;
            end
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    // Called a little after a rising edge, so the checks land well before the next one.
    task automatic async_reset(input string tag);
        rst_n = 1'b0;
        #2;
        model_reset();
        check_all(tag);
        check({tag, ".ir_nop"}, {24'd0, ir}, 32'hF0);
        check({tag, ".valid0"}, {31'd0, ir_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = 8'h20 | 8'(i);
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Straight-line fetch with constant ready
        rom[0] = 8'h12;
        rom[1] = 8'h34;
        ir_ready = 1'b1;
        step("seq1");
        check("seq1.ir12", {24'd0, ir}, 32'h12);
        check("seq1.pc0", {28'd0, pc}, 32'd0);
        step("seq2");
        check("seq2.pc1", {28'd0, pc}, 32'd1);
        step("seq3");
        check("seq3.ir34", {24'd0, ir}, 32'h34);
        step("seq4");
        check("seq4.pc2", {28'd0, pc}, 32'd2);
        check("seq4.ret2", {24'd0, retired}, 32'd2);

        // Stall for five cycles
        async_reset("rst_a");
        ir_ready = 1'b0;
        step("stall_f");
        for (int i = 0; i < 5; i++) step("stall");
        check("stall.ir", {24'd0, ir}, 32'h12);
        ir_ready = 1'b1;
        step("stall_rel");
        check("stall.ret1", {24'd0, retired}, 32'd1);
        check("stall.pc1", {28'd0, pc}, 32'd1);

        // Branch at pc=3, then a branch pulse outside an accept
        async_reset("rst_b");
        for (int i = 0; i < 20 && !(m_pc == 4'd3 && m_valid); i++) step("to3");
        check("to3.reached", {31'd0, m_valid}, 32'd1);
        branch_taken = 1'b1;
        branch_target = 4'hA;
        step("br");
        check("br.pcA", {28'd0, pc}, 32'd10);
        branch_taken = 1'b0;
        step("br_fetch");
        check("br.ir", {24'd0, ir}, {24'd0, rom[10]});
        ir_ready = 1'b0;
        branch_taken = 1'b1;
        branch_target = 4'h5;
        step("br_noacc");
        check("br_noacc.pc", {28'd0, pc}, 32'd10);
        ir_ready = 1'b1;
        branch_taken = 1'b0;
        step("br_after");
        check("br_after.pc", {28'd0, pc}, 32'd11);

        // Sequential run through the wrap
        for (int i = 0; i < 40; i++) step("wrap");

        // Halt at pc=2, inputs afterwards ignored
        async_reset("rst_c");
        rom[2] = 8'hE0;
        for (int i = 0; i < 6; i++) step("halt_run");
        check("halt.halted", {31'd0, halted}, 32'd1);
        check("halt.pc2", {28'd0, pc}, 32'd2);
        check("halt.ret3", {24'd0, retired}, 32'd3);
        for (int i = 0; i < 10; i++) begin
            ir_ready = 1'($urandom);
            branch_taken = 1'($urandom);
            branch_target = 4'($urandom);
            step("halt_frz");
        end
        check("halt_frz.ret3", {24'd0, retired}, 32'd3);
        async_reset("rst_d");
        check("rst_d.halted0", {31'd0, halted}, 32'd0);
        rom[2] = 8'h22;

        // Retire counter saturation via a branch loop to 0
        ir_ready = 1'b1;
        branch_taken = 1'b1;
        branch_target = 4'h0;
        for (int i = 0; i < 600; i++) step("sat");
        check("sat.ret255", {24'd0, retired}, 32'd255);
        ir_ready = 1'b0;
        branch_taken = 1'b0;
        step("sat_f");
        step("sat_stall");
        async_reset("rst_e");

        // Random ROM contents and handshake/branch traffic
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
            for (int i = 0; i < 300; i++) begin
                ir_ready = ($urandom_range(0, 3) != 0);
                branch_taken = 1'($urandom);
                branch_target = 4'($urandom);
                step("rnd");
            end
            async_reset("rst_rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
